dff_ram: RTL and testbench

Flip-flop-based single-port synchronous RAM with a registered read port, used as the weight and bias parameter store inside the wake-word detector's convolution parameter memory (`conv_mem`). It holds DEPTH words of WIDTH bits. It performs one read or one write per cycle on a shared address, gated by a global enable. Storage is built from flip-flops, so the whole array is cleared by reset.

---
 rtl/dff_ram.sv | 34 +++
 tb/tb_dff_ram.sv | 102 ++++++++++
 2 files changed

// File: rtl/dff_ram.sv
// dff_ram: flip-flop single-port RAM with registered, read-first output and reset-cleared array
module dff_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_en_i,
  input  logic              en_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [WIDTH-1:0]  data_i,
  output logic [WIDTH-1:0]  data_o
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_data;
  // Address decode by comparison so out-of-range addresses read 0 and never index past the array
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < DEPTH; i++)
      if (addr_i == ADDR_W'(i)) rd_data = mem[i];
  end
  // Read-first access: output captures the pre-write word; reset clears everything
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      data_o <= '0;
    end else if (en_i) begin
      data_o <= rd_data;
      for (int i = 0; i < DEPTH; i++)
        if (wr_en_i && addr_i == ADDR_W'(i)) mem[i] <= data_i;
    end
  end
endmodule

// File: tb/tb_dff_ram.sv
// tb_dff_ram: directed plus random checks of two dff_ram configurations against an array model
module tb_dff_ram;
  logic clk = 0;
  logic rst;
  logic en_a, we_a, en_b, we_b;
  logic [2:0] addr_a, addr_b;
  logic [7:0] din_a, dout_a;
  logic [15:0] din_b, dout_b;
  logic [7:0] ref_a [8];
  logic [15:0] ref_b [5];
  logic [7:0] exp_a;
  logic [15:0] exp_b;
  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  dff_ram #(.WIDTH(8), .DEPTH(8)) u_a (
    .clk_i(clk), .rst_i(rst), .wr_en_i(we_a), .en_i(en_a),
    .addr_i(addr_a), .data_i(din_a), .data_o(dout_a)
  );
  dff_ram #(.WIDTH(16), .DEPTH(5)) u_b (
    .clk_i(clk), .rst_i(rst), .wr_en_i(we_b), .en_i(en_b),
    .addr_i(addr_b), .data_i(din_b), .data_o(dout_b)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    tests++;
    assert (obs === expv) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic step(input logic ea, input logic wa, input logic [2:0] aa, input logic [7:0] da,
                      input logic eb, input logic wb, input logic [2:0] ab, input logic [15:0] db,
                      input string tag);
    en_a = ea; we_a = wa; addr_a = aa; din_a = da;
    en_b = eb; we_b = wb; addr_b = ab; din_b = db;
    @(posedge clk);
    if (rst) begin
      foreach (ref_a[i]) ref_a[i] = '0;
      foreach (ref_b[i]) ref_b[i] = '0;
      exp_a = '0;
      exp_b = '0;
    end else begin
      if (ea) begin
        exp_a = ref_a[aa];
        if (wa) ref_a[aa] = da;
      end
      if (eb) begin
        exp_b = (ab < 5) ? ref_b[ab] : 16'h0;
        if (wb && ab < 5) ref_b[ab] = db;
      end
    end
    #1;
    chk({tag, "_a"}, {8'h0, dout_a}, {8'h0, exp_a});
    chk({tag, "_b"}, dout_b, exp_b);
  endtask

  task automatic sa(input logic ea, input logic wa, input logic [2:0] aa, input logic [7:0] da, input string tag);
    step(ea, wa, aa, da, 1'b0, 1'b0, 3'd0, 16'h0, tag);
  endtask

  initial begin
    rst = 0;
    en_a = 0; we_a = 0; addr_a = 0; din_a = 0;
    en_b = 0; we_b = 0; addr_b = 0; din_b = 0;
    @(negedge clk);
    rst = 1;
    sa(0, 0, 0, 0, "reset_init");
    rst = 0;
    for (int k = 0; k < 8; k++) sa(1, 1, 3'(k), 8'hA5, "fill_a5");
    rst = 1;
    sa(0, 0, 0, 0, "reset_clear");
    rst = 0;
    for (int k = 0; k < 8; k++) sa(1, 0, 3'(k), 8'h0, "read_cleared");
    for (int k = 0; k < 8; k++) sa(1, 1, 3'(k), 8'(8'h10 + k), "sweep_wr");
    for (int k = 0; k < 8; k++) sa(1, 0, 3'(k), 8'h0, "sweep_rd");
    sa(1, 1, 3, 8'h22, "coll_prep");
    sa(1, 1, 3, 8'h77, "coll_rdfirst");
    sa(1, 0, 3, 8'h0, "coll_new");
    for (int k = 0; k < 3; k++) sa(0, 1, 3, 8'h00, "gate_hold");
    sa(1, 0, 3, 8'h0, "gate_after");
    step(0, 0, 0, 0, 1, 1, 4, 16'h1234, "npot_w4");
    step(0, 0, 0, 0, 1, 1, 6, 16'hBEEF, "npot_w6");
    step(0, 0, 0, 0, 1, 0, 6, 16'h0, "npot_r6");
    step(0, 0, 0, 0, 1, 0, 4, 16'h0, "npot_r4");
    for (int k = 0; k < 5; k++) step(0, 0, 0, 0, 1, 0, 3'(k), 16'h0, "npot_scan");
    for (int n = 0; n < 300; n++)
      step(1'($urandom), 1'($urandom), 3'($urandom), 8'($urandom),
           1'($urandom), 1'($urandom), 3'($urandom), 16'($urandom), "rand");
    sa(1, 1, 1, 8'h5C, "rstwr_prep");
    rst = 1;
    sa(1, 1, 1, 8'hFF, "rstwr_edge");
    rst = 0;
    sa(1, 0, 1, 8'h0, "rstwr_read");
    for (int k = 0; k < 5; k++) step(0, 0, 0, 0, 1, 0, 3'(k), 16'h0, "rst_scan_b");
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
